ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_LEN, default 8: RAM address width in bits.
REQ-002 Parameter DATA_LEN, default 8: RAM data width in bits.
REQ-003 Parameter NUM_CLIENTS, default 4: number of requesters, range 2..8.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 c_wreq  in  NUM_CLIENTS  per-client write request.
REQ-007 c_waddr  in  NUM_CLIENTS x ADDR_LEN  per-client write address.
REQ-008 c_wdata  in  NUM_CLIENTS x DATA_LEN  per-client write data.
REQ-009 c_wgnt  out  NUM_CLIENTS  one-hot write grant, combinational, same cycle as the write.
REQ-010 c_rreq  in  NUM_CLIENTS  per-client read request.
REQ-011 c_raddr  in  NUM_CLIENTS x ADDR_LEN  per-client read address.
REQ-012 c_rgnt  out  NUM_CLIENTS  one-hot read grant, combinational.
REQ-013 c_rvalid  out  NUM_CLIENTS  one-hot registered read-data-valid pulse.
REQ-014 c_rdata  out  DATA_LEN  registered read data, shared by all clients.
REQ-015 ram_write, ram_inaddr, ram_indata  out  1/ADDR_LEN/DATA_LEN  RAM write port.
REQ-016 ram_read, ram_outaddr  out  1/ADDR_LEN  RAM read port.
REQ-017 ram_outdata  in  DATA_LEN  RAM combinational read data; high-Z when ram_read low.

Function
REQ-018 Write and read paths SHALL be arbitrated independently; one write and one read MAY be granted in the same cycle.
REQ-019 Each path SHALL use round-robin: pointer ptr names the highest-priority client; the first requester at or after ptr (modulo NUM_CLIENTS) is granted.
REQ-020 After a grant to client k, that path's ptr SHALL become (k+1) mod NUM_CLIENTS at the next edge; with no requests ptr SHALL hold.
REQ-021 At most one bit of c_wgnt and of c_rgnt SHALL be set; a grant SHALL only be given to a requesting client.
REQ-022 When a write is granted to k: ram_write=1, ram_inaddr=c_waddr[k], ram_indata=c_wdata[k] in that cycle; otherwise ram_write=0 and address/data SHALL be 0.
REQ-023 When a read is granted to k: ram_read=1, ram_outaddr=c_raddr[k] in that cycle; otherwise ram_read=0, ram_outaddr=0.
REQ-024 Read latency SHALL be 1 cycle: on the edge ending a granted read, c_rdata captures ram_outdata and c_rvalid[k] is set for exactly one cycle.
REQ-025 c_rdata SHALL hold its last value when no read is granted; ram_outdata SHALL never be sampled while ram_read=0.
REQ-026 Same-address write and read in one cycle: the read SHALL return the pre-write (old) data.
REQ-027 A client SHALL hold req, address and data stable until granted; a deasserted request is simply not considered (no queued state).
REQ-028 Back-to-back reads SHALL sustain one read per cycle, with c_rvalid following each grant by one cycle.
REQ-029 With all clients requesting continuously, each client SHALL be granted once every NUM_CLIENTS cycles per path (no starvation).

Reset
REQ-030 While rst_n=0: both ptr=0, c_rvalid=0, c_rdata=0, regardless of clock.
REQ-031 While rst_n=0, c_wgnt, c_rgnt, ram_write and ram_read SHALL be 0; RAM contents are not affected.
REQ-032 A read granted in the cycle reset asserts SHALL produce no c_rvalid after reset release.

Structure
REQ-033 Package ram_arb_pkg SHALL hold the client-index type (clog2 of NUM_CLIENTS max) and the default parameter constants.
REQ-034 Sub-module rr_arbiter (request vector in, one-hot grant and index out, owns its ptr) SHALL be instantiated twice: write path and read path.

Verification
REQ-035 Reset release, client 2 writes 0xA5 to 0x10, next cycle client 1 reads 0x10 -> c_rgnt=0b0010, one cycle later c_rvalid=0b0010, c_rdata=0xA5.
REQ-036 All 4 clients hold c_rreq for 8 cycles from reset -> c_rgnt sequence 0,1,2,3,0,1,2,3 (client index), c_rvalid identical sequence delayed 1 cycle.
REQ-037 Memory 0x20=0x11; same cycle write 0x22 to 0x20 and read 0x20 -> c_rdata=0x11; repeated read next cycle -> 0x22.
REQ-038 Clients 0 and 3 request writes after grant to client 3 (ptr=0) -> client 0 granted first, then 3.
REQ-039 Assert rst_n=0 mid-cycle during granted read -> c_rvalid=0, c_rdata=0 immediately; no c_rvalid after release; ptr=0.
REQ-040 No requests for 5 cycles -> ram_write=ram_read=0 throughout, c_rdata unchanged, ptrs unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RAM arbiter and its round-robin sub-arbiters.
package ram_arb_pkg;

   localparam int unsigned DEF_ADDR_LEN    = 8;
   localparam int unsigned DEF_DATA_LEN    = 8;
   localparam int unsigned DEF_NUM_CLIENTS = 4;
   localparam int unsigned MAX_CLIENTS     = 8;
   localparam int unsigned IDX_W           = $clog2(MAX_CLIENTS);

   typedef logic [IDX_W-1:0] client_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, then moves ptr past the winner.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned N = DEF_NUM_CLIENTS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt_c,
   output client_idx_t  idx_c,
   output logic         any_c
);

   client_idx_t ptr_q, ptr_d;

   // Two passes: requesters at/after ptr first, then wrap around from client 0.
   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      ptr_d = ptr_q;
      for (int unsigned j = 0; j < N; j++) begin
         if (!any_c && req[j] && (j >= 32'(ptr_q))) begin
            gnt_c[j] = 1'b1;
            idx_c    = client_idx_t'(j);
            any_c    = 1'b1;
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!any_c && req[j]) begin
            gnt_c[j] = 1'b1;
            idx_c    = client_idx_t'(j);
            any_c    = 1'b1;
         end
      end
      if (!rst_n) begin
         gnt_c = '0;
         idx_c = '0;
         any_c = 1'b0;
      end
      if (any_c) begin
         ptr_d = (idx_c == client_idx_t'(N - 1)) ? '0 : idx_c + client_idx_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-client RAM arbiter: independent round-robin write and read paths onto a
// single-port-per-direction RAM, with one-cycle registered read return.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_LEN    = DEF_ADDR_LEN,
   parameter int unsigned DATA_LEN    = DEF_DATA_LEN,
   parameter int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CLIENTS-1:0]                 c_wreq,
   input  logic [NUM_CLIENTS-1:0][ADDR_LEN-1:0]   c_waddr,
   input  logic [NUM_CLIENTS-1:0][DATA_LEN-1:0]   c_wdata,
   output logic [NUM_CLIENTS-1:0]                 c_wgnt,
   input  logic [NUM_CLIENTS-1:0]                 c_rreq,
   input  logic [NUM_CLIENTS-1:0][ADDR_LEN-1:0]   c_raddr,
   output logic [NUM_CLIENTS-1:0]                 c_rgnt,
   output logic [NUM_CLIENTS-1:0]                 c_rvalid,
   output logic [DATA_LEN-1:0]                    c_rdata,
   output logic                                   ram_write,
   output logic [ADDR_LEN-1:0]                    ram_inaddr,
   output logic [DATA_LEN-1:0]                    ram_indata,
   output logic                                   ram_read,
   output logic [ADDR_LEN-1:0]                    ram_outaddr,
   input  logic [DATA_LEN-1:0]                    ram_outdata
);

   logic [NUM_CLIENTS-1:0] wgnt_c, rgnt_c;
   client_idx_t            widx_c, ridx_c;
   logic                   w_any_c, r_any_c;

   logic [NUM_CLIENTS-1:0] rvalid_q, rvalid_d;
   logic [DATA_LEN-1:0]    rdata_q, rdata_d;

   rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (c_wreq),
      .gnt_c (wgnt_c),
      .idx_c (widx_c),
      .any_c (w_any_c)
   );

   rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (c_rreq),
      .gnt_c (rgnt_c),
      .idx_c (ridx_c),
      .any_c (r_any_c)
   );

   // Winner's address/data onto the RAM ports; zeros when the path is idle.
   always_comb begin
      ram_inaddr  = '0;
      ram_indata  = '0;
      ram_outaddr = '0;
      for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
         if (w_any_c && (widx_c == client_idx_t'(j))) begin
            ram_inaddr = c_waddr[j];
            ram_indata = c_wdata[j];
         end
         if (r_any_c && (ridx_c == client_idx_t'(j))) begin
            ram_outaddr = c_raddr[j];
         end
      end
   end

   // Read data is only sampled while a read is granted, so idle high-Z never reaches c_rdata.
   always_comb begin
      rvalid_d = rgnt_c;
      rdata_d  = r_any_c ? ram_outdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign c_wgnt    = wgnt_c;
   assign c_rgnt    = rgnt_c;
   assign ram_write = w_any_c;
   assign ram_read  = r_any_c;
   assign c_rvalid  = rvalid_q;
   assign c_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM; each task checks one scenario inline.
module tb_ram_arbiter;

   logic             clk;
   logic             rst_n;
   logic [3:0]       c_wreq;
   logic [3:0][7:0]  c_waddr;
   logic [3:0][7:0]  c_wdata;
   logic [3:0]       c_wgnt;
   logic [3:0]       c_rreq;
   logic [3:0][7:0]  c_raddr;
   logic [3:0]       c_rgnt;
   logic [3:0]       c_rvalid;
   logic [7:0]       c_rdata;
   logic             ram_write;
   logic [7:0]       ram_inaddr;
   logic [7:0]       ram_indata;
   logic             ram_read;
   logic [7:0]       ram_outaddr;
   logic [7:0]       ram_outdata;

   logic [7:0]       mem [256];

   int n_cmp;
   int n_fail;

   ram_arbiter #(.ADDR_LEN(8), .DATA_LEN(8), .NUM_CLIENTS(4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .c_wreq      (c_wreq),
      .c_waddr     (c_waddr),
      .c_wdata     (c_wdata),
      .c_wgnt      (c_wgnt),
      .c_rreq      (c_rreq),
      .c_raddr     (c_raddr),
      .c_rgnt      (c_rgnt),
      .c_rvalid    (c_rvalid),
      .c_rdata     (c_rdata),
      .ram_write   (ram_write),
      .ram_inaddr  (ram_inaddr),
      .ram_indata  (ram_indata),
      .ram_read    (ram_read),
      .ram_outaddr (ram_outaddr),
      .ram_outdata (ram_outdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write) mem[ram_inaddr] <= ram_indata;
   end

   // A poison value stands in for high-Z so any sample taken while idle is visible.
   assign ram_outdata = ram_read ? mem[ram_outaddr] : 8'hEE;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #1;
      c_wreq = 4'b1111;
      c_rreq = 4'b1111;
      #1;
      n_cmp++; if (c_wgnt !== 4'b0000) begin n_fail++; $display("FAIL rst_wgnt: got %b exp 0000", c_wgnt); end
      n_cmp++; if (c_rgnt !== 4'b0000) begin n_fail++; $display("FAIL rst_rgnt: got %b exp 0000", c_rgnt); end
      n_cmp++; if (ram_write !== 1'b0 || ram_read !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got w=%b r=%b exp 0 0", ram_write, ram_read); end
      tick();
      n_cmp++; if (c_rvalid !== 4'b0000) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 0000", c_rvalid); end
      n_cmp++; if (c_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h exp 00", c_rdata); end
      n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd0 || u_dut.u_rd_arb.ptr_q !== 3'd0) begin n_fail++; $display("FAIL rst_ptr: got w=%0d r=%0d exp 0 0", u_dut.u_wr_arb.ptr_q, u_dut.u_rd_arb.ptr_q); end
      c_wreq = 4'b0000;
      c_rreq = 4'b0000;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      c_wreq     = 4'b0100;
      c_waddr[2] = 8'h10;
      c_wdata[2] = 8'hA5;
      #1;
      n_cmp++; if (c_wgnt !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt: got %b exp 0100", c_wgnt); end
      n_cmp++; if (ram_write !== 1'b1 || ram_inaddr !== 8'h10 || ram_indata !== 8'hA5) begin n_fail++; $display("FAIL wr_port: got %b %h %h exp 1 10 a5", ram_write, ram_inaddr, ram_indata); end
      tick();
      n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd3) begin n_fail++; $display("FAIL wr_ptr: got %0d exp 3", u_dut.u_wr_arb.ptr_q); end
      c_wreq     = 4'b0000;
      c_rreq     = 4'b0010;
      c_raddr[1] = 8'h10;
      #1;
      n_cmp++; if (c_rgnt !== 4'b0010) begin n_fail++; $display("FAIL rd_gnt: got %b exp 0010", c_rgnt); end
      n_cmp++; if (ram_read !== 1'b1 || ram_outaddr !== 8'h10 || ram_write !== 1'b0 || ram_inaddr !== 8'h00) begin n_fail++; $display("FAIL rd_port: got r=%b a=%h w=%b wa=%h exp 1 10 0 00", ram_read, ram_outaddr, ram_write, ram_inaddr); end
      tick();
      n_cmp++; if (c_rvalid !== 4'b0010) begin n_fail++; $display("FAIL rd_valid: got %b exp 0010", c_rvalid); end
      n_cmp++; if (c_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h exp a5", c_rdata); end
      c_rreq = 4'b0000;
      tick();
      n_cmp++; if (c_rvalid !== 4'b0000) begin n_fail++; $display("FAIL rd_valid_pulse: got %b exp 0000", c_rvalid); end
      n_cmp++; if (c_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data_hold: got %h exp a5", c_rdata); end
   endtask

   task automatic test_rr_read();
      logic [3:0] exp_g;
      do_reset();
      for (int j = 0; j < 4; j++) c_raddr[j] = 8'h10;
      c_rreq = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         exp_g = 4'b0001 << (i % 4);
         #1;
         n_cmp++; if (c_rgnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, c_rgnt, exp_g); end
         tick();
         n_cmp++; if (c_rvalid !== exp_g) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b exp %b", i, c_rvalid, exp_g); end
         n_cmp++; if (c_rdata !== 8'hA5) begin n_fail++; $display("FAIL rr_data[%0d]: got %h exp a5", i, c_rdata); end
      end
      c_rreq = 4'b0000;
   endtask

   task automatic test_same_addr();
      c_wreq     = 4'b0001;
      c_waddr[0] = 8'h20;
      c_wdata[0] = 8'h11;
      #1;
      n_cmp++; if (c_wgnt !== 4'b0001) begin n_fail++; $display("FAIL sa_pre_gnt: got %b exp 0001", c_wgnt); end
      tick();
      c_wreq     = 4'b0010;
      c_waddr[1] = 8'h20;
      c_wdata[1] = 8'h22;
      c_rreq     = 4'b0100;
      c_raddr[2] = 8'h20;
      #1;
      n_cmp++; if (c_wgnt !== 4'b0010 || c_rgnt !== 4'b0100) begin n_fail++; $display("FAIL sa_dual_gnt: got w=%b r=%b exp 0010 0100", c_wgnt, c_rgnt); end
      n_cmp++; if (ram_inaddr !== 8'h20 || ram_indata !== 8'h22 || ram_outaddr !== 8'h20) begin n_fail++; $display("FAIL sa_ports: got %h %h %h exp 20 22 20", ram_inaddr, ram_indata, ram_outaddr); end
      tick();
      n_cmp++; if (c_rdata !== 8'h11 || c_rvalid !== 4'b0100) begin n_fail++; $display("FAIL sa_old_data: got %h v=%b exp 11 0100", c_rdata, c_rvalid); end
      c_wreq = 4'b0000;
      tick();
      n_cmp++; if (c_rdata !== 8'h22 || c_rvalid !== 4'b0100) begin n_fail++; $display("FAIL sa_new_data: got %h v=%b exp 22 0100", c_rdata, c_rvalid); end
      c_rreq = 4'b0000;
   endtask

   task automatic test_wr_priority();
      c_wreq     = 4'b1000;
      c_waddr[3] = 8'h30;
      c_wdata[3] = 8'h33;
      #1;
      n_cmp++; if (c_wgnt !== 4'b1000) begin n_fail++; $display("FAIL pr_gnt3: got %b exp 1000", c_wgnt); end
      tick();
      n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd0) begin n_fail++; $display("FAIL pr_ptr_wrap: got %0d exp 0", u_dut.u_wr_arb.ptr_q); end
      c_wreq     = 4'b1001;
      c_waddr[0] = 8'h31;
      c_wdata[0] = 8'h44;
      #1;
      n_cmp++; if (c_wgnt !== 4'b0001 || ram_inaddr !== 8'h31 || ram_indata !== 8'h44) begin n_fail++; $display("FAIL pr_first: got %b %h %h exp 0001 31 44", c_wgnt, ram_inaddr, ram_indata); end
      tick();
      n_cmp++; if (c_wgnt !== 4'b1000 || ram_inaddr !== 8'h30 || ram_indata !== 8'h33) begin n_fail++; $display("FAIL pr_second: got %b %h %h exp 1000 30 33", c_wgnt, ram_inaddr, ram_indata); end
      tick();
      n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd0) begin n_fail++; $display("FAIL pr_ptr_end: got %0d exp 0", u_dut.u_wr_arb.ptr_q); end
      c_wreq = 4'b0000;
   endtask

   task automatic test_reset_mid_read();
      c_rreq     = 4'b0001;
      c_raddr[0] = 8'h20;
      #1;
      n_cmp++; if (c_rgnt !== 4'b0001) begin n_fail++; $display("FAIL mr_gnt: got %b exp 0001", c_rgnt); end
      tick();
      n_cmp++; if (c_rvalid !== 4'b0001 || c_rdata !== 8'h22) begin n_fail++; $display("FAIL mr_pre: got v=%b d=%h exp 0001 22", c_rvalid, c_rdata); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (c_rvalid !== 4'b0000 || c_rdata !== 8'h00) begin n_fail++; $display("FAIL mr_async: got v=%b d=%h exp 0000 00", c_rvalid, c_rdata); end
      n_cmp++; if (c_rgnt !== 4'b0000 || ram_read !== 1'b0) begin n_fail++; $display("FAIL mr_gnt_off: got %b r=%b exp 0000 0", c_rgnt, ram_read); end
      tick();
      c_rreq = 4'b0000;
      #2 rst_n = 1'b1;
      tick();
      n_cmp++; if (c_rvalid !== 4'b0000 || c_rdata !== 8'h00) begin n_fail++; $display("FAIL mr_release: got v=%b d=%h exp 0000 00", c_rvalid, c_rdata); end
      n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd0 || u_dut.u_rd_arb.ptr_q !== 3'd0) begin n_fail++; $display("FAIL mr_ptr: got w=%0d r=%0d exp 0 0", u_dut.u_wr_arb.ptr_q, u_dut.u_rd_arb.ptr_q); end
   endtask

   task automatic test_idle();
      c_rreq     = 4'b0010;
      c_raddr[1] = 8'h10;
      tick();
      n_cmp++; if (c_rvalid !== 4'b0010 || c_rdata !== 8'hA5) begin n_fail++; $display("FAIL id_setup: got v=%b d=%h exp 0010 a5", c_rvalid, c_rdata); end
      c_rreq = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (ram_write !== 1'b0 || ram_read !== 1'b0) begin n_fail++; $display("FAIL id_en[%0d]: got w=%b r=%b exp 0 0", i, ram_write, ram_read); end
         tick();
         n_cmp++; if (c_rdata !== 8'hA5 || c_rvalid !== 4'b0000) begin n_fail++; $display("FAIL id_data[%0d]: got d=%h v=%b exp a5 0000", i, c_rdata, c_rvalid); end
         n_cmp++; if (u_dut.u_wr_arb.ptr_q !== 3'd0 || u_dut.u_rd_arb.ptr_q !== 3'd2) begin n_fail++; $display("FAIL id_ptr[%0d]: got w=%0d r=%0d exp 0 2", i, u_dut.u_wr_arb.ptr_q, u_dut.u_rd_arb.ptr_q); end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      c_wreq  = '0;
      c_waddr = '0;
      c_wdata = '0;
      c_rreq  = '0;
      c_raddr = '0;
      test_reset();
      test_write_read();
      test_rr_read();
      test_same_addr();
      test_wr_priority();
      test_reset_mid_read();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
